ram512_arbiter: RTL and testbench
=================================

Name: ram512_arbiter

Overview:
- Two-requester controller that shares one 512x16 RAM (synchronous write, combinational read) between ports A and B.
- Optionally zero-fills the whole RAM after reset.
- Sequences one RAM access per cycle, using round-robin arbitration and a req/ack handshake with a registered read data path.
- Sits between two client engines and the RAM instance. It is the RAM's only driver.

Parameters:
AW, 9, RAM address width (depth = 2**AW)
DW, 16, RAM data width
CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = go straight to RUN

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
a_req  input  1  port A request, held until a_ack
a_we  input  1  port A: 1 = write, 0 = read
a_add  input  AW  port A word address
a_in  input  DW  port A write data
a_ack  output  1  port A one-cycle completion pulse
a_o  output  DW  port A read data, valid while a_ack=1 after a read
b_req, b_we, b_add, b_in, b_ack, b_o  same as port A, for port B
busy  output  1  high while clear sequence runs
ram_load  output  1  RAM write enable
ram_add  output  AW  RAM address
ram_in  output  DW  RAM write data
ram_o  input  DW  RAM read data (combinational from ram_add)

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset values:
  - state = CLEAR if CLEAR_ON_RESET, else RUN
  - clr_cnt = 0; prio = A
  - a_ack = b_ack = 0; a_o = b_o = 0
  - busy = CLEAR_ON_RESET
- ram_load is gated combinationally by rst_n, so the RAM is never written while reset is asserted.
- State CLEAR:
  - ram_add = clr_cnt, ram_in = 0, ram_load = 1, busy = 1; no acks issued.
  - clr_cnt increments each cycle.
  - On the cycle clr_cnt = 2**AW-1, move to RUN. The clear takes exactly 512 cycles, and busy drops in cycle 513.
  - Requests made during CLEAR are held pending, not lost.
- State RUN, per cycle:
  - A requester is eligible when its req=1 and its ack=0. The ack cycle is a dead cycle for that requester, which prevents double-service of a held req.
  - If exactly one requester is eligible, it wins.
  - If both are eligible, the side named by prio wins, and prio is then set to the other side.
  - A single winner does not change prio.
  - Winner drives ram_add = x_add and ram_in = x_in (combinational mux). ram_load = x_we.
  - If there is no winner: ram_load = 0, and ram_add/ram_in hold the last values (don't care).
  - Next edge:
    - Winner's x_ack = 1 for exactly one cycle.
    - On a read, x_o <= ram_o.
    - On a write, x_o holds its previous value.
    - The loser's ack stays 0, and its request stays pending.
- Latency: ack arrives 1 cycle after the grant cycle; a write is committed at the same edge.
- Throughput:
  - A single requester is served every other cycle.
  - Two continuous requesters alternate A,B,A,B at one access per cycle.
- Same-address ordering: accesses complete in grant order. A read granted after a write sees the new data.
- Requesters must hold req/we/add/in stable until ack. They may drop req in the ack cycle, or keep it high to queue the next access.
- Reset asserted mid-clear or mid-access: all state returns to reset values at once, and the clear restarts at address 0. A pending ack is dropped, and the requester must re-request.
- Width rules: address and data pass through unchanged. clr_cnt is AW+1 bits or wraps cleanly at terminal count; no overflow side effects.

Decomposition:
- Shared package: state encoding (CLEAR, RUN), prio encoding (PRIO_A, PRIO_B), AW/DW defaults.
- One natural sub-module, rr_arb2: a 2-way round-robin arbiter taking eligible[1:0] and prio, producing grant[1:0] and next_prio.
- The clear counter, datapath mux and ack/read-data registers stay in the top module.

Test Plan:
- CLEAR_ON_RESET=1, release rst_n:
  - busy stays high exactly 512 cycles.
  - ram_load=1 with ram_add stepping 0..511 and ram_in=0.
  - A follow-up read of addr 0x1FF returns 0x0000.
- A alone:
  - Write 0x1A5 <= 0xBEEF; a_ack pulses 1 cycle later.
  - Then read 0x1A5: a_o = 0xBEEF on the a_ack cycle.
  - Holding a_req high yields an ack every second cycle.
- Both req from the same cycle, continuous:
  - A writes 0x010 <= 0x1111, B writes 0x020 <= 0x2222.
  - Grants go A,B,A,B starting with A; a_ack and b_ack alternate every cycle.
  - Neither side waits more than 1 cycle.
- Same address:
  - A writes 0x055 <= 0xCAFE and B reads 0x055 simultaneously with prio=A.
  - B's b_o = 0xCAFE; with prio=B instead, b_o returns the old value.
- Requests during clear:
  - a_req asserted at cycle 10 of the clear.
  - No ack until after busy falls; first ack arrives 1 cycle after the first RUN cycle.
- Reset mid-operation:
  - Assert rst_n=0 at clear cycle 300: ram_load drops immediately, all acks = 0.
  - On release the clear restarts at address 0 and takes a full 512 cycles.

Source files
------------

// File: rtl/ram512_arbiter_pkg.sv
// Shared types and defaults for the two-port RAM arbiter: controller states,
// round-robin priority encoding and the grant bit positions.
package ram512_arbiter_pkg;

  localparam int AW_DEF = 9;
  localparam int DW_DEF = 16;

  // Bit positions of each requester in the eligible/grant vectors
  localparam int GNT_A = 0;
  localparam int GNT_B = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  function automatic prio_e other_side(input prio_e p);
    return (p == PRIO_A) ? PRIO_B : PRIO_A;
  endfunction

endpackage

// File: rtl/ram512_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone eligible requester wins outright; on a
// conflict the prioritised side wins and priority flips to the other side.
module ram512_arbiter_rr_arb2
  import ram512_arbiter_pkg::*;
(
  input  logic [1:0] eligible_i,
  input  prio_e      prio_i,
  output logic [1:0] grant_o,
  output prio_e      next_prio_o
);

  always_comb begin
    grant_o     = 2'b00;
    next_prio_o = prio_i;
    case (eligible_i)
      2'b01: grant_o = 2'b01;
      2'b10: grant_o = 2'b10;
      2'b11: begin
        grant_o[GNT_A] = (prio_i == PRIO_A);
        grant_o[GNT_B] = (prio_i == PRIO_B);
        next_prio_o    = other_side(prio_i);
      end
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram512_arbiter.sv
// Shares one synchronous-write / combinational-read RAM between two req/ack
// clients, one access per cycle, with an optional zero-fill pass after reset.
module ram512_arbiter
  import ram512_arbiter_pkg::*;
#(
  parameter int AW             = AW_DEF,
  parameter int DW             = DW_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_add,
  input  logic [DW-1:0] a_in,
  output logic          a_ack,
  output logic [DW-1:0] a_o,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_add,
  input  logic [DW-1:0] b_in,
  output logic          b_ack,
  output logic [DW-1:0] b_o,
  output logic          busy,
  output logic          ram_load,
  output logic [AW-1:0] ram_add,
  output logic [DW-1:0] ram_in,
  input  logic [DW-1:0] ram_o
);

  localparam logic [AW-1:0] CLR_LAST    = '1;
  localparam state_e        RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  prio_e         prio_q, prio_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic [DW-1:0] a_o_q, a_o_d;
  logic [DW-1:0] b_o_q, b_o_d;
  logic [AW-1:0] hold_add_q, hold_add_d;
  logic [DW-1:0] hold_in_q, hold_in_d;

  logic [1:0]    eligible;
  logic [1:0]    grant;
  prio_e         next_prio;
  logic [AW-1:0] mux_add;
  logic [DW-1:0] mux_in;
  logic          mux_we;

  // The ack cycle is a dead cycle for that side so a held req is not re-served
  assign eligible[GNT_A] = (state_q == ST_RUN) & a_req & ~a_ack_q;
  assign eligible[GNT_B] = (state_q == ST_RUN) & b_req & ~b_ack_q;

  ram512_arbiter_rr_arb2 u_rr_arb2 (
    .eligible_i  (eligible),
    .prio_i      (prio_q),
    .grant_o     (grant),
    .next_prio_o (next_prio)
  );

  always_comb begin
    mux_add = hold_add_q;
    mux_in  = hold_in_q;
    mux_we  = 1'b0;
    if (state_q == ST_CLEAR) begin
      mux_add = clr_cnt_q;
      mux_in  = '0;
      mux_we  = 1'b1;
    end else if (grant[GNT_A]) begin
      mux_add = a_add;
      mux_in  = a_in;
      mux_we  = a_we;
    end else if (grant[GNT_B]) begin
      mux_add = b_add;
      mux_in  = b_in;
      mux_we  = b_we;
    end
  end

  // Write enable is gated by reset itself so nothing lands in the RAM while held
  assign ram_load = mux_we & rst_n;
  assign ram_add  = mux_add;
  assign ram_in   = mux_in;
  assign busy     = (state_q == ST_CLEAR);
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_o      = a_o_q;
  assign b_o      = b_o_q;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    prio_d     = next_prio;
    a_ack_d    = grant[GNT_A];
    b_ack_d    = grant[GNT_B];
    a_o_d      = (grant[GNT_A] & ~a_we) ? ram_o : a_o_q;
    b_o_d      = (grant[GNT_B] & ~b_we) ? ram_o : b_o_q;
    hold_add_d = mux_add;
    hold_in_d  = mux_in;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == CLR_LAST) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      clr_cnt_q  <= '0;
      prio_q     <= PRIO_A;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_o_q      <= '0;
      b_o_q      <= '0;
      hold_add_q <= '0;
      hold_in_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      prio_q     <= prio_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_o_q      <= a_o_d;
      b_o_q      <= b_o_d;
      hold_add_q <= hold_add_d;
      hold_in_q  <= hold_in_d;
    end
  end

endmodule

// File: tb/tb_ram512_arbiter.sv
// Randomised and directed bench for ram512_arbiter: a transaction-level model
// predicts each ack and its read data into per-port queues, a monitor checks them.
module tb_ram512_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [8:0]  a_add, b_add;
  logic [15:0] a_in, b_in;
  logic        a_ack, b_ack, busy, ram_load;
  logic [15:0] a_o, b_o;
  logic [8:0]  ram_add;
  logic [15:0] ram_in, ram_o;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram512_arbiter #(.AW(9), .DW(16), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_add(a_add), .a_in(a_in), .a_ack(a_ack), .a_o(a_o),
    .b_req(b_req), .b_we(b_we), .b_add(b_add), .b_in(b_in), .b_ack(b_ack), .b_o(b_o),
    .busy(busy), .ram_load(ram_load), .ram_add(ram_add), .ram_in(ram_in), .ram_o(ram_o)
  );

  // RAM instance the controller drives
  logic [15:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = 16'h0;
  always @(posedge clk) if (ram_load) mem[ram_add] <= ram_in;
  assign ram_o = mem[ram_add];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          rd;
    logic [15:0] data;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] m_mem [512];
  int          clear_left = 512;
  int          m_prio = 0;     // 0 = A has priority, 1 = B
  bit          m_aack = 0;
  bit          m_back = 0;

  always @(negedge clk) begin
    bit ea, eb;
    int win;
    if (!rst_n) begin
      chk("rst_busy", busy, 1);
      chk("rst_ram_load", ram_load, 0);
      chk("rst_a_ack", a_ack, 0);
      chk("rst_b_ack", b_ack, 0);
      chk("rst_a_o", a_o, 0);
      chk("rst_b_o", b_o, 0);
      clear_left = 512;
      m_prio = 0;
      m_aack = 0;
      m_back = 0;
      qa.delete();
      qb.delete();
    end else if (clear_left > 0) begin
      chk("clr_busy", busy, 1);
      chk("clr_ram_load", ram_load, 1);
      chk("clr_ram_add", ram_add, 512 - clear_left);
      chk("clr_ram_in", ram_in, 0);
      chk("clr_no_a_ack", a_ack, 0);
      chk("clr_no_b_ack", b_ack, 0);
      clear_left--;
      if (clear_left == 0) for (int i = 0; i < 512; i++) m_mem[i] = 16'h0;
    end else begin
      chk("run_busy", busy, 0);
      ea  = a_req && !m_aack;
      eb  = b_req && !m_back;
      win = -1;
      if (ea && eb) begin
        win    = m_prio;
        m_prio = 1 - m_prio;
      end else if (ea) begin
        win = 0;
      end else if (eb) begin
        win = 1;
      end
      m_aack = (win == 0);
      m_back = (win == 1);
      if (win == 0) begin
        chk("a_grant_load", ram_load, a_we);
        chk("a_grant_add", ram_add, a_add);
        if (a_we) chk("a_grant_in", ram_in, a_in);
        qa.push_back('{due: cyc + 1, rd: !a_we, data: m_mem[a_add]});
        if (a_we) m_mem[a_add] = a_in;
      end else if (win == 1) begin
        chk("b_grant_load", ram_load, b_we);
        chk("b_grant_add", ram_add, b_add);
        if (b_we) chk("b_grant_in", ram_in, b_in);
        qb.push_back('{due: cyc + 1, rd: !b_we, data: m_mem[b_add]});
        if (b_we) m_mem[b_add] = b_in;
      end else begin
        chk("idle_ram_load", ram_load, 0);
      end
    end
  end

  // ---------------- monitor ----------------
  exp_t ma, mb;
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_ack) begin
        if (qa.size() == 0) chk("a_ack_unexpected", a_ack, 0);
        else begin
          ma = qa.pop_front();
          chk("a_ack_cycle", cyc, ma.due);
          if (ma.rd) chk("a_rdata", a_o, ma.data);
          $display("cyc %0d  A %s data=%h", cyc, ma.rd ? "rd" : "wr", a_o);
        end
      end else if (qa.size() > 0 && qa[0].due <= cyc) begin
        chk("a_ack_missing", a_ack, 1);
        void'(qa.pop_front());
      end
      if (b_ack) begin
        if (qb.size() == 0) chk("b_ack_unexpected", b_ack, 0);
        else begin
          mb = qb.pop_front();
          chk("b_ack_cycle", cyc, mb.due);
          if (mb.rd) chk("b_rdata", b_o, mb.data);
          $display("cyc %0d  B %s data=%h", cyc, mb.rd ? "rd" : "wr", b_o);
        end
      end else if (qb.size() > 0 && qb[0].due <= cyc) begin
        chk("b_ack_missing", b_ack, 1);
        void'(qb.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [8:0] add, input logic [15:0] din);
    if (p == 0) begin a_req = req; a_we = we; a_add = add; a_in = din; end
    else        begin b_req = req; b_we = we; b_add = add; b_in = din; end
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? a_ack : b_ack;
  endfunction

  // Called at posedge+1; returns in the ack cycle at posedge+1
  task automatic access(input int p, input logic we, input logic [8:0] add,
                        input logic [15:0] din, input bit keep,
                        output logic [15:0] rd, output int lat);
    set_port(p, 1'b1, we, add, din);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!get_ack(p) && lat < 2000);
    chk("ack_seen", get_ack(p), 1);
    rd = (p == 0) ? a_o : b_o;
    if (!keep) set_port(p, 1'b0, we, add, din);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    while (busy && n < 1000) begin @(posedge clk); #1; n++; end
    chk("busy_cycles", n, 512);
  endtask

  task automatic rand_client(input int p, input int n);
    logic [15:0] r;
    int          l;
    bit          keep;
    for (int i = 0; i < n; i++) begin
      keep = 1'($urandom_range(0, 1));
      access(p, 1'($urandom_range(0, 1)), 9'(9'h060 + $urandom_range(0, 7)),
             16'($urandom), keep, r, l);
      if (!keep) idle($urandom_range(0, 3));
    end
    set_port(p, 0, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] r, rb;
    int          l, lb;
    rst_n = 1'b1;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    idle(2);
    rst_n = 1'b1;
    wait_clear();
    access(0, 1'b0, 9'h1FF, 16'h0, 1'b0, r, l);
    chk("clear_read_1ff", r, 16'h0000);

    // A alone: write then read back, then back-to-back held requests
    idle(1);
    access(0, 1'b1, 9'h1A5, 16'hBEEF, 1'b0, r, l);
    chk("a_write_latency", l, 1);
    access(0, 1'b0, 9'h1A5, 16'h0, 1'b0, r, l);
    chk("a_read_1a5", r, 16'hBEEF);
    for (int i = 0; i < 6; i++) begin
      access(0, 1'(i % 2), 9'(9'h100 + i), 16'(16'h7000 + i), i < 5, r, l);
      chk("a_alone_every_2nd", l, 2);
    end

    // Both continuous from the same cycle: A first, then strict alternation
    idle(1);
    fork
      begin
        logic [15:0] ra; int la;
        for (int i = 0; i < 8; i++) begin
          access(0, 1'b1, 9'h010, 16'h1111, i < 7, ra, la);
          chk("both_a_latency", la, (i == 0) ? 1 : 2);
        end
      end
      begin
        logic [15:0] rbb; int lbb;
        for (int i = 0; i < 8; i++) begin
          access(1, 1'b1, 9'h020, 16'h2222, i < 7, rbb, lbb);
          chk("both_b_latency", lbb, 2);
        end
      end
    join
    idle(1);
    access(1, 1'b0, 9'h010, 16'h0, 1'b0, r, l);
    chk("b_reads_a_data", r, 16'h1111);

    // Same address, prio = A after a fresh reset, then prio = B
    do_reset();
    wait_clear();
    fork
      access(0, 1'b1, 9'h055, 16'hCAFE, 1'b0, r, l);
      access(1, 1'b0, 9'h055, 16'h0, 1'b0, rb, lb);
    join
    chk("same_addr_prio_a_new", rb, 16'hCAFE);
    idle(1);
    fork
      access(0, 1'b1, 9'h055, 16'h1234, 1'b0, r, l);
      access(1, 1'b0, 9'h055, 16'h0, 1'b0, rb, lb);
    join
    chk("same_addr_prio_b_old", rb, 16'hCAFE);
    idle(1);
    access(0, 1'b0, 9'h055, 16'h0, 1'b0, r, l);
    chk("same_addr_final", r, 16'h1234);

    // Random traffic on a small address window to force collisions
    idle(1);
    fork
      rand_client(0, 40);
      rand_client(1, 40);
    join
    idle(2);

    // Request raised at clear cycle 10: served right after the clear
    do_reset();
    idle(9);
    access(0, 1'b1, 9'h0AB, 16'h5A5A, 1'b0, r, l);
    chk("clear_req_latency", l, 504);

    // Reset in the middle of the clear restarts it from address 0
    idle(1);
    do_reset();
    idle(299);
    rst_n = 1'b0;
    #1;
    chk("midclr_ram_load", ram_load, 0);
    chk("midclr_a_ack", a_ack, 0);
    chk("midclr_b_ack", b_ack, 0);
    idle(2);
    rst_n = 1'b1;
    wait_clear();
    access(0, 1'b0, 9'h0AB, 16'h0, 1'b0, r, l);
    chk("recleared_0ab", r, 16'h0000);

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
